// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-box, Rcon, xtime, key-size check and FSM states.
// Words are big-endian throughout: byte 0 of a word or block sits in the top bits.
package aes_pkg;

    localparam int BLK_S = 128;

    typedef enum logic [2:0] {
        IDLE,
        KEXP,
        READY,
        ROUND,
        OUT
    } aes_st_e;

    // Forward S-box, entry 0x00 in the top byte
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] lsb;
        lsb = 11'd2040 - {x, 3'b000};
        return SBOX_TBL[lsb +: 8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit key_s_legal(input int k);
        return (k == 128) || (k == 192) || (k == 256);
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; last_i drops MixColumns for the final round.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    for (genvar n = 0; n < 16; n++) begin : g_sub
        assign sb[n] = sbox(state_i[127-8*n -: 8]);
    end

    // Byte 4c+r is row r of column c; row r rotates left by r columns
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c+r] = sb[4*((c+r)%4)+r];
        end
        assign mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
        assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end

    for (genvar n = 0; n < 16; n++) begin : g_ark
        assign state_o[127-8*n -: 8] = (last_i ? sr[n] : mc[n]) ^ rk_i[127-8*n -: 8];
    end

endmodule

// File: rtl/aes_engine.sv
// Iterative AES encryptor: key expansion one word per cycle, then one round per cycle.
// Round keys persist across blocks; only a new key transfer or reset invalidates them.
module aes_engine
    import aes_pkg::*;
#(
    parameter int KEY_S = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_key_valid,
    output logic             s_key_ready,
    input  logic [KEY_S-1:0] s_key,
    input  logic             s_blk_valid,
    output logic             s_blk_ready,
    input  logic [127:0]     s_blk,
    output logic             m_blk_valid,
    input  logic             m_blk_ready,
    output logic [127:0]     m_blk,
    output logic             key_loaded,
    output logic             busy,
    output logic             err_nokey
);

    localparam int NK     = KEY_S / 32;
    localparam int NR     = NK + 6;
    localparam int LAST_W = 4 * NR + 3;

    if (!key_s_legal(KEY_S)) begin : g_bad_key_s
        $error("aes_engine: KEY_S must be 128, 192 or 256");
    end

    aes_st_e                st_q;
    logic                   key_loaded_q;
    logic                   m_valid_q;
    logic [127:0]           m_blk_q;
    logic [127:0]           blk_q;
    logic [5:0]             wi_q;
    logic [2:0]             kc_q;
    logic [3:0]             rci_q;
    logic [3:0]             rnd_q;
    logic [NK-1:0][31:0]    win_q;
    logic [3:0][31:0]       rk_q [NR+1];

    logic                   key_xfer;
    logic                   blk_xfer;
    logic [31:0]            w_tmp;
    logic [31:0]            w_new_d;
    logic [127:0]           rnd_d;

    assign s_key_ready = reset || st_q == IDLE || st_q == READY;
    assign s_blk_ready = !reset && st_q == READY && !s_key_valid;
    assign err_nokey   = !reset && s_blk_valid && !key_loaded_q;
    assign busy        = !reset && !(st_q == IDLE || st_q == READY);
    assign key_loaded  = !reset && key_loaded_q;
    assign m_blk_valid = m_valid_q;
    assign m_blk       = m_blk_q;

    assign key_xfer = s_key_valid && s_key_ready;
    assign blk_xfer = s_blk_valid && s_blk_ready;

    // win_q[0] is w[i-1], win_q[NK-1] is w[i-Nk]; kc_q tracks i mod Nk
    always_comb begin
        w_tmp = win_q[0];
        if (kc_q == 3'd0) begin
            w_tmp = subword({win_q[0][23:0], win_q[0][31:24]}) ^ {rcon(rci_q), 24'h0};
        end else if (NK == 8 && kc_q == 3'd4) begin
            w_tmp = subword(win_q[0]);
        end
        w_new_d = win_q[NK-1] ^ w_tmp;
    end

    aes_round u_round (
        .state_i (blk_q),
        .rk_i    (rk_q[rnd_q]),
        .last_i  (rnd_q == 4'(NR)),
        .state_o (rnd_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q         <= IDLE;
            key_loaded_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_blk_q      <= '0;
            wi_q         <= '0;
            kc_q         <= '0;
            rci_q        <= '0;
            rnd_q        <= '0;
        end else begin
            case (st_q)
                IDLE, READY: begin
                    if (key_xfer) begin
                        st_q         <= KEXP;
                        key_loaded_q <= 1'b0;
                        wi_q         <= 6'(NK);
                        kc_q         <= 3'd0;
                        rci_q        <= 4'd1;
                    end else if (blk_xfer) begin
                        st_q  <= ROUND;
                        rnd_q <= 4'd1;
                    end
                end
                KEXP: begin
                    wi_q <= wi_q + 6'd1;
                    kc_q <= (kc_q == 3'(NK-1)) ? 3'd0 : kc_q + 3'd1;
                    if (kc_q == 3'd0) rci_q <= rci_q + 4'd1;
                    if (wi_q == 6'(LAST_W)) begin
                        st_q         <= READY;
                        key_loaded_q <= 1'b1;
                    end
                end
                ROUND: begin
                    if (rnd_q == 4'(NR)) begin
                        st_q      <= OUT;
                        m_valid_q <= 1'b1;
                        m_blk_q   <= rnd_d;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                OUT: begin
                    if (m_blk_ready) begin
                        st_q      <= READY;
                        m_valid_q <= 1'b0;
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end

    // Key and state storage needs no reset: key_loaded_q qualifies it
    always_ff @(posedge clk) begin
        if (key_xfer) begin
            win_q <= s_key;
            for (int j = 0; j < NK; j++) begin
                rk_q[4'(j/4)][2'(3-j%4)] <= s_key[KEY_S-1-32*j -: 32];
            end
        end else if (st_q == KEXP) begin
            win_q                    <= {win_q[NK-2:0], w_new_d};
            rk_q[wi_q[5:2]][~wi_q[1:0]] <= w_new_d;
        end

        if (blk_xfer) begin
            blk_q <= s_blk ^ rk_q[0];
        end else if (st_q == ROUND) begin
            blk_q <= rnd_d;
        end
    end

endmodule

// File: tb/tb_aes_engine.sv
// Directed bench for aes_engine: three instances (128/192/256-bit keys) driven with FIPS-197 vectors.
module tb_aes_engine;

    localparam logic [255:0] KEY128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEYB   = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   kv, kr, bv, br, mv, mr, kl, bz, en;
    logic [127:0] k128;
    logic [191:0] k192;
    logic [255:0] k256;
    logic [127:0] sblk [3];
    logic [127:0] mblk [3];
    int           n_pass = 0;
    int           n_total = 0;

    always #5 clk = ~clk;

    aes_engine #(.KEY_S(128)) u128 (
        .clk(clk), .reset(reset), .s_key_valid(kv[0]), .s_key_ready(kr[0]), .s_key(k128),
        .s_blk_valid(bv[0]), .s_blk_ready(br[0]), .s_blk(sblk[0]), .m_blk_valid(mv[0]),
        .m_blk_ready(mr[0]), .m_blk(mblk[0]), .key_loaded(kl[0]), .busy(bz[0]), .err_nokey(en[0]));
    aes_engine #(.KEY_S(192)) u192 (
        .clk(clk), .reset(reset), .s_key_valid(kv[1]), .s_key_ready(kr[1]), .s_key(k192),
        .s_blk_valid(bv[1]), .s_blk_ready(br[1]), .s_blk(sblk[1]), .m_blk_valid(mv[1]),
        .m_blk_ready(mr[1]), .m_blk(mblk[1]), .key_loaded(kl[1]), .busy(bz[1]), .err_nokey(en[1]));
    aes_engine #(.KEY_S(256)) u256 (
        .clk(clk), .reset(reset), .s_key_valid(kv[2]), .s_key_ready(kr[2]), .s_key(k256),
        .s_blk_valid(bv[2]), .s_blk_ready(br[2]), .s_blk(sblk[2]), .m_blk_valid(mv[2]),
        .m_blk_ready(mr[2]), .m_blk(mblk[2]), .key_loaded(kl[2]), .busy(bz[2]), .err_nokey(en[2]));

    task automatic load_key(input int k, input logic [255:0] key, input int exp_cyc);
        int t, nb;
        @(negedge clk);
        case (k)
            0:       k128 = key[127:0];
            1:       k192 = key[191:0];
            default: k256 = key;
        endcase
        kv[k] = 1'b1;
        @(posedge clk); #1;
        kv[k] = 1'b0;
        t = 0; nb = 0;
        while (t < 200) begin
            @(negedge clk);
            t++;
            if (kl[k]) break;
            if (bz[k]) nb++;
        end
        n_total++;
        if (kl[k] !== 1'b1 || nb != exp_cyc)
            $display("FAIL kexp_len[%0d]: got %0d cycles loaded=%b, want %0d cycles loaded=1", k, nb, kl[k], exp_cyc);
        else n_pass++;
    endtask

    task automatic offer_blk(input int k, input logic [127:0] blk);
        int t;
        @(negedge clk);
        sblk[k] = blk;
        bv[k] = 1'b1;
        #1;
        t = 0;
        while (!br[k] && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        n_total++;
        if (br[k] !== 1'b1) $display("FAIL blk_accept[%0d]: s_blk_ready=%b, want 1", k, br[k]);
        else n_pass++;
        @(posedge clk); #1;
        bv[k] = 1'b0;
    endtask

    task automatic get_out(input int k, input logic [127:0] exp, input int exp_lat, input bit rel);
        int t;
        @(negedge clk);
        t = 1;
        while (!mv[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_total++;
        if (mv[k] !== 1'b1 || t != exp_lat)
            $display("FAIL latency[%0d]: got %0d valid=%b, want %0d valid=1", k, t, mv[k], exp_lat);
        else n_pass++;
        n_total++;
        if (mblk[k] !== exp) $display("FAIL m_blk[%0d]: got %h, want %h", k, mblk[k], exp);
        else n_pass++;
        if (rel) begin
            mr[k] = 1'b1;
            @(posedge clk); #1;
            mr[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if ({kr[k], br[k], mv[k], kl[k], bz[k], en[k]} !== 6'b100000 || mblk[k] !== 128'h0)
                $display("FAIL reset_state[%0d]: got kr/br/mv/kl/bz/en=%b m_blk=%h, want 100000 and 0",
                         k, {kr[k], br[k], mv[k], kl[k], bz[k], en[k]}, mblk[k]);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    task automatic test_nokey();
        @(negedge clk);
        sblk[0] = PT_A;
        bv[0] = 1'b1;
        repeat (5) begin
            #1;
            n_total++;
            if (en[0] !== 1'b1 || br[0] !== 1'b0 || mv[0] !== 1'b0)
                $display("FAIL nokey: got err=%b ready=%b valid=%b, want 1 0 0", en[0], br[0], mv[0]);
            else n_pass++;
            @(negedge clk);
        end
        bv[0] = 1'b0;
        #1;
        n_total++;
        if (en[0] !== 1'b0) $display("FAIL nokey_clear: got err=%b, want 0", en[0]);
        else n_pass++;
    endtask

    task automatic test_vectors();
        load_key(0, KEY128, 40);
        offer_blk(0, PT_A);
        get_out(0, CT128, 11, 1'b1);
        load_key(1, KEY192, 46);
        offer_blk(1, PT_A);
        get_out(1, CT192, 13, 1'b1);
        load_key(2, KEY256, 52);
        offer_blk(2, PT_A);
        get_out(2, CT256, 15, 1'b1);
    endtask

    task automatic test_backpressure();
        offer_blk(0, PT_A);
        get_out(0, CT128, 11, 1'b0);
        sblk[0] = PT_A;
        bv[0] = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
            n_total++;
            if (mv[0] !== 1'b1 || mblk[0] !== CT128 || br[0] !== 1'b0)
                $display("FAIL stall: got valid=%b m_blk=%h ready=%b, want 1 %h 0", mv[0], mblk[0], br[0], CT128);
            else n_pass++;
        end
        mr[0] = 1'b1;
        @(posedge clk); #1;
        mr[0] = 1'b0;
        @(negedge clk); #1;
        n_total++;
        if (br[0] !== 1'b1 || mv[0] !== 1'b0)
            $display("FAIL release: got ready=%b valid=%b, want 1 0", br[0], mv[0]);
        else n_pass++;
        @(posedge clk); #1;
        bv[0] = 1'b0;
        get_out(0, CT128, 11, 1'b1);
    endtask

    task automatic test_key_priority();
        int t;
        @(negedge clk);
        k128 = KEYB[127:0];
        kv[0] = 1'b1;
        sblk[0] = PT_B;
        bv[0] = 1'b1;
        #1;
        n_total++;
        if (br[0] !== 1'b0 || kr[0] !== 1'b1)
            $display("FAIL priority: got blk_ready=%b key_ready=%b, want 0 1", br[0], kr[0]);
        else n_pass++;
        @(posedge clk); #1;
        kv[0] = 1'b0;
        t = 0;
        while (t < 200) begin
            @(negedge clk); #1;
            t++;
            if (br[0]) break;
        end
        n_total++;
        if (br[0] !== 1'b1 || t != 41)
            $display("FAIL blk_stall: got ready after %0d cycles (ready=%b), want 41", t, br[0]);
        else n_pass++;
        @(posedge clk); #1;
        bv[0] = 1'b0;
        get_out(0, CT_B, 11, 1'b1);
    endtask

    task automatic test_reset_round();
        bit seen;
        offer_blk(0, PT_A);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (mv[0]) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0 || kl[0] !== 1'b0)
            $display("FAIL abort: got valid_seen=%b key_loaded=%b, want 0 0", seen, kl[0]);
        else n_pass++;
        sblk[0] = PT_A;
        bv[0] = 1'b1;
        #1;
        n_total++;
        if (br[0] !== 1'b0 || en[0] !== 1'b1)
            $display("FAIL abort_nokey: got ready=%b err=%b, want 0 1", br[0], en[0]);
        else n_pass++;
        @(negedge clk);
        bv[0] = 1'b0;
        load_key(0, KEY128, 40);
        offer_blk(0, PT_A);
        get_out(0, CT128, 11, 1'b1);
    endtask

    initial begin
        kv = '0; bv = '0; mr = '0;
        k128 = '0; k192 = '0; k256 = '0;
        for (int k = 0; k < 3; k++) sblk[k] = '0;
        test_reset();
        test_nokey();
        test_vectors();
        test_backpressure();
        test_key_priority();
        test_reset_round();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
